// File: rtl/bitmap_instance_scheduler.sv
// Shares one sprite bitmap between N_INST instances. Each pixel is hit-tested, the lowest index wins, and a tag is registered to match the bitmap's latency.
// Optional macro SCHED_COLLISION_EN adds the collision and frameCollision outputs.
module bitmap_instance_scheduler #(
    parameter int unsigned N_INST       = 4,
    parameter int unsigned OBJ_W        = 32,
    parameter int unsigned OBJ_H        = 32,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        cfgWe,
    input  logic [2:0]  cfgIdx,
    input  logic [10:0] cfgX,
    input  logic [10:0] cfgY,
    input  logic [1:0]  cfgMode,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic        hitValid,
    output logic [2:0]  hitIndex,
    output logic        blinkPhase
`ifdef SCHED_COLLISION_EN
    ,
    output logic        collision,
    output logic        frameCollision
`endif
);

    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  mode;
    } inst_cfg_t;

    inst_cfg_t            pend_cfg [N_INST];
    inst_cfg_t            act_cfg  [N_INST];
    inst_cfg_t            wr_cfg;
    logic [N_INST-1:0]    wr_sel;
    logic [N_INST-1:0]    hits;
    logic [CNT_W-1:0]     frame_cnt;
    logic                 win_any;
    logic [2:0]           win_idx;
    logic [10:0]          win_x;
    logic [10:0]          win_y;
    logic                 multi_hit;

    assign wr_cfg = '{x: cfgX, y: cfgY, mode: cfgMode};

    // Write select; indices at or above N_INST match no instance and are dropped
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < N_INST; i++) begin
            wr_sel[i] = cfgWe && (cfgIdx == 3'(i));
        end
    end

    // Pending/active double buffer; a same-cycle write bypasses into active
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_INST; i++) begin
                pend_cfg[i] <= '0;
                act_cfg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_INST; i++) begin
                if (wr_sel[i]) begin
                    pend_cfg[i] <= wr_cfg;
                end
                if (startOfFrame) begin
                    act_cfg[i] <= wr_sel[i] ? wr_cfg : pend_cfg[i];
                end
            end
        end
    end

    // Blink sequencer, stepped once per frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt  <= '0;
            blinkPhase <= 1'b0;
        end else if (startOfFrame) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt  <= '0;
                blinkPhase <= ~blinkPhase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Rectangle test at 12 bits so rectangles near 2047 do not wrap to 0
    always_comb begin
        hits = '0;
        for (int i = 0; i < N_INST; i++) begin
            hits[i] = ((act_cfg[i].mode == MODE_ON) ||
                       ((act_cfg[i].mode == MODE_BLINK) && !blinkPhase)) &&
                      ({1'b0, pixelX} >= {1'b0, act_cfg[i].x}) &&
                      ({1'b0, pixelX} <  {1'b0, act_cfg[i].x} + 12'(OBJ_W)) &&
                      ({1'b0, pixelY} >= {1'b0, act_cfg[i].y}) &&
                      ({1'b0, pixelY} <  {1'b0, act_cfg[i].y} + 12'(OBJ_H));
        end
    end

    // Descending scan so the lowest hitting index is the last assignment
    always_comb begin
        win_any   = 1'b0;
        win_idx   = '0;
        win_x     = '0;
        win_y     = '0;
        multi_hit = 1'b0;
        for (int i = N_INST - 1; i >= 0; i--) begin
            if (hits[i]) begin
                multi_hit = win_any;
                win_any   = 1'b1;
                win_idx   = 3'(i);
                win_x     = act_cfg[i].x;
                win_y     = act_cfg[i].y;
            end
        end
        InsideRectangle = win_any;
        offsetX         = win_any ? (pixelX - win_x) : '0;
        offsetY         = win_any ? (pixelY - win_y) : '0;
    end

    // Stage 1 tag aligned with bitmap RGBout
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitValid <= 1'b0;
            hitIndex <= '0;
        end else begin
            hitValid <= win_any;
            hitIndex <= win_idx;
        end
    end

`ifdef SCHED_COLLISION_EN
    logic frame_acc;

    // Collision flag plus per-frame sticky result held for the following frame
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collision      <= 1'b0;
            frame_acc      <= 1'b0;
            frameCollision <= 1'b0;
        end else begin
            collision <= multi_hit;
            if (startOfFrame) begin
                frameCollision <= frame_acc | collision;
                frame_acc      <= 1'b0;
            end else begin
                frame_acc <= frame_acc | collision;
            end
        end
    end
`else
    logic unused_multi;
    assign unused_multi = multi_hit;
`endif

endmodule
